// File: rtl/fetch_control_pkg.sv
// Shared fetch/PC-control definitions.
// Contents:
//   fetch_state_e   - fetch controller FSM states (BOOT, RUN, WAIT_MEM)
//   RANK_*          - redirect source ranks; higher value wins arbitration
//   SEL_*           - next_PC_select codes understood by the PC register
package fetch_control_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_MEM = 2'd2
    } fetch_state_e;

    localparam logic [1:0] RANK_NONE   = 2'd0;
    localparam logic [1:0] RANK_JUMP   = 2'd1;
    localparam logic [1:0] RANK_BRANCH = 2'd2;
    localparam logic [1:0] RANK_TRAP   = 2'd3;

    localparam logic [1:0] SEL_INCR = 2'b00;
    localparam logic [1:0] SEL_HOLD = 2'b01;
    localparam logic [1:0] SEL_LOAD = 2'b10;

endpackage

// File: rtl/fetch_control_redirect_arbiter.sv
// redirect_arbiter: purely combinational choice between the redirect
// requests arriving this cycle and the redirect already parked in the
// pending register.
// Ports:
//   trap_*/branch_*/jump_*   - incoming redirect requests and targets
//   stall                    - decode stall; masks jump requests
//   pending_*                - current pending redirect entry
//   new_rank/new_target      - best request arriving this cycle (rank 0 = none)
//   new_wins                 - new request beats (or replaces) the pending entry
//   sel_valid/rank/target    - redirect to apply if memory accepts this cycle
module redirect_arbiter
    import fetch_control_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 32
) (
    input  logic                    trap_valid,
    input  logic [ADDRESS_BITS-1:0] trap_target,
    input  logic                    branch_valid,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic                    jump_valid,
    input  logic [ADDRESS_BITS-1:0] jump_target,
    input  logic                    stall,
    input  logic                    pending_valid,
    input  logic [1:0]              pending_rank,
    input  logic [ADDRESS_BITS-1:0] pending_target,
    output logic [1:0]              new_rank,
    output logic [ADDRESS_BITS-1:0] new_target,
    output logic                    new_wins,
    output logic                    sel_valid,
    output logic [1:0]              sel_rank,
    output logic [ADDRESS_BITS-1:0] sel_target
);

    always_comb begin
        new_rank   = RANK_NONE;
        new_target = '0;
        if (trap_valid) begin
            new_rank   = RANK_TRAP;
            new_target = trap_target;
        end else if (branch_valid) begin
            new_rank   = RANK_BRANCH;
            new_target = branch_target;
        end else if (jump_valid && !stall) begin
            // A stalled decode stage has not really issued its jump yet.
            new_rank   = RANK_JUMP;
            new_target = jump_target;
        end

        // Ties go to the newer request; a trap therefore always wins.
        new_wins = (new_rank != RANK_NONE) &&
                   (!pending_valid || (new_rank >= pending_rank));

        sel_valid  = new_wins || pending_valid;
        sel_rank   = RANK_NONE;
        sel_target = '0;
        if (new_wins) begin
            sel_rank   = new_rank;
            sel_target = new_target;
        end else if (pending_valid) begin
            sel_rank   = pending_rank;
            sel_target = pending_target;
        end
    end

endmodule

// File: rtl/fetch_control.sv
// fetch_control: decides each cycle how the PC register advances
// (increment / hold / load redirect target), parks redirects that arrive
// while instruction memory is busy, and issues pipeline flushes.
// Ports:
//   clock, reset (active-low, asynchronous)
//   trap_*, branch_*, jump_*   - redirect requests (rank trap > branch > jump)
//   stall                      - decode hazard stall
//   i_mem_ready                - memory accepts a new fetch address this cycle
//   next_PC_select, target_PC  - PC register control; target only valid on load
//   flush_fetch, flush_decode  - kill instructions in fetch / decode
//   redirect_count             - saturating count of applied redirects
//   fsm_state                  - current FSM state, for observation
//
// Handshake: i_mem_ready is the ready half of the fetch address handshake.
// The PC presented this cycle is taken by memory only when i_mem_ready=1,
// so the PC may only change (increment or load) in such a cycle; when it is
// low the PC holds and any redirect is parked until memory accepts.
module fetch_control
    import fetch_control_pkg::*;
#(
    parameter int                    CORE         = 0,
    parameter int unsigned           ADDRESS_BITS = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC   = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    trap_valid,
    input  logic [ADDRESS_BITS-1:0] trap_target,
    input  logic                    branch_valid,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic                    jump_valid,
    input  logic [ADDRESS_BITS-1:0] jump_target,
    input  logic                    stall,
    input  logic                    i_mem_ready,
    output logic [1:0]              next_PC_select,
    output logic [ADDRESS_BITS-1:0] target_PC,
    output logic                    flush_fetch,
    output logic                    flush_decode,
    output logic [31:0]             redirect_count,
    output logic [1:0]              fsm_state
);

    // The boot address is owned by the PC register; the core index is
    // informational. Neither affects this controller's behaviour.
    logic unused_params;
    assign unused_params = ^{CORE, RESET_PC};

    fetch_state_e            state, next_state;
    logic                    pending_valid;
    logic [1:0]              pending_rank;
    logic [ADDRESS_BITS-1:0] pending_target;
    logic [31:0]             count_q;

    logic [1:0]              new_rank;
    logic [ADDRESS_BITS-1:0] new_target;
    logic                    new_wins;
    logic                    sel_valid;
    logic [1:0]              sel_rank;
    logic [ADDRESS_BITS-1:0] sel_target;

    logic                    capture;
    logic                    apply;
    logic [1:0]              flush_rank;

    redirect_arbiter #(
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_arbiter (
        .trap_valid     (trap_valid),
        .trap_target    (trap_target),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .jump_valid     (jump_valid),
        .jump_target    (jump_target),
        .stall          (stall),
        .pending_valid  (pending_valid),
        .pending_rank   (pending_rank),
        .pending_target (pending_target),
        .new_rank       (new_rank),
        .new_target     (new_target),
        .new_wins       (new_wins),
        .sel_valid      (sel_valid),
        .sel_rank       (sel_rank),
        .sel_target     (sel_target)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        next_PC_select = SEL_HOLD;
        target_PC      = '0;
        capture        = 1'b0;
        apply          = 1'b0;
        flush_rank     = RANK_NONE;

        case (state)
            ST_BOOT: begin
                // One hold cycle so the PC register loads its boot address.
                next_state = ST_RUN;
            end
            ST_RUN, ST_WAIT_MEM: begin
                if (!i_mem_ready) begin
                    next_state = ST_WAIT_MEM;
                    capture    = new_wins;
                    flush_rank = new_wins ? new_rank : RANK_NONE;
                end else begin
                    next_state = ST_RUN;
                    if (sel_valid) begin
                        // Redirects are never delayed by stall.
                        next_PC_select = SEL_LOAD;
                        target_PC      = sel_target;
                        apply          = 1'b1;
                        flush_rank     = sel_rank;
                    end else if (stall) begin
                        next_PC_select = SEL_HOLD;
                    end else begin
                        next_PC_select = SEL_INCR;
                    end
                end
            end
            default: begin
                next_state = ST_BOOT;
            end
        endcase

        flush_fetch  = capture || apply;
        flush_decode = (capture || apply) && (flush_rank >= RANK_BRANCH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_valid  <= 1'b0;
            pending_rank   <= RANK_NONE;
            pending_target <= '0;
        end else if (capture) begin
            pending_valid  <= 1'b1;
            pending_rank   <= new_rank;
            pending_target <= new_target;
        end else if (apply) begin
            // Whatever was parked is either applied now or superseded.
            pending_valid  <= 1'b0;
            pending_rank   <= RANK_NONE;
            pending_target <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (apply && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign redirect_count = count_q;
    assign fsm_state      = state;

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: directed scenarios followed by
// random traffic, checked against a behavioural model via an expected queue.
module tb_fetch_control;

    localparam int EW = 68;   // {select[1:0], target[31:0], ff, fd, count[31:0]}

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_target = '0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_target = '0;
    logic        stall = 1'b0;
    logic        i_mem_ready = 1'b0;
    logic [1:0]  next_PC_select;
    logic [31:0] target_PC;
    logic        flush_fetch;
    logic        flush_decode;
    logic [31:0] redirect_count;
    logic [1:0]  fsm_state;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int cycle_no = 0;

    // behavioural model state
    bit          m_boot = 1'b1;
    bit          m_pv = 1'b0;
    int          m_prank = 0;
    logic [31:0] m_ptgt = '0;
    logic [31:0] m_count = '0;

    bit          do_preload = 1'b0;
    logic [31:0] preload_val = '0;

    fetch_control #(
        .CORE         (0),
        .ADDRESS_BITS (32),
        .RESET_PC     (32'h100)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .trap_valid     (trap_valid),
        .trap_target    (trap_target),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .jump_valid     (jump_valid),
        .jump_target    (jump_target),
        .stall          (stall),
        .i_mem_ready    (i_mem_ready),
        .next_PC_select (next_PC_select),
        .target_PC      (target_PC),
        .flush_fetch    (flush_fetch),
        .flush_decode   (flush_decode),
        .redirect_count (redirect_count),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    task automatic model_step(input bit rst_asserted,
                              input bit tv, input logic [31:0] tt,
                              input bit bv, input logic [31:0] bt,
                              input bit jv, input logic [31:0] jt,
                              input bit st, input bit rdy);
        logic [1:0]  e_sel;
        logic [31:0] e_tgt;
        logic [31:0] e_cnt;
        logic [31:0] tgt;
        bit          e_ff, e_fd, wins;
        int          rank;
        e_sel = 2'b01;
        e_tgt = '0;
        e_ff  = 1'b0;
        e_fd  = 1'b0;
        if (rst_asserted) begin
            m_boot  = 1'b1;
            m_pv    = 1'b0;
            m_prank = 0;
            m_ptgt  = '0;
            m_count = '0;
        end
        e_cnt = m_count;
        if (!rst_asserted) begin
            if (m_boot) begin
                m_boot = 1'b0;
            end else begin
                rank = 0;
                tgt  = '0;
                if (tv) begin
                    rank = 3; tgt = tt;
                end else if (bv) begin
                    rank = 2; tgt = bt;
                end else if (jv && !st) begin
                    rank = 1; tgt = jt;
                end
                wins = (rank > 0) && (!m_pv || rank >= m_prank);
                if (!rdy) begin
                    if (wins) begin
                        m_pv = 1'b1; m_prank = rank; m_ptgt = tgt;
                        e_ff = 1'b1; e_fd = (rank >= 2);
                    end
                end else if (wins || m_pv) begin
                    if (!wins) begin
                        rank = m_prank; tgt = m_ptgt;
                    end
                    e_sel = 2'b10;
                    e_tgt = tgt;
                    e_ff  = 1'b1;
                    e_fd  = (rank >= 2);
                    m_pv  = 1'b0;
                    if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
                end else begin
                    e_sel = st ? 2'b01 : 2'b00;
                end
            end
        end
        exp_q.push_back({e_sel, e_tgt, e_ff, e_fd, e_cnt});
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input bit rst_asserted,
                               input bit tv, input logic [31:0] tt,
                               input bit bv, input logic [31:0] bt,
                               input bit jv, input logic [31:0] jt,
                               input bit st, input bit rdy);
        @(posedge clock);
        #1;
        reset         = ~rst_asserted;
        trap_valid    = tv;
        trap_target   = tt;
        branch_valid  = bv;
        branch_target = bt;
        jump_valid    = jv;
        jump_target   = jt;
        stall         = st;
        i_mem_ready   = rdy;
        if (do_preload) begin
            force dut.count_q = preload_val;
            #1;
            release dut.count_q;
            m_count    = preload_val;
            do_preload = 1'b0;
        end
        model_step(rst_asserted, tv, tt, bv, bt, jv, jt, st, rdy);
    endtask

    task automatic idle(input bit rdy, input bit st);
        drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, st, rdy);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cycle_no, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [EW-1:0] e;
        cycle_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("next_PC_select", {30'd0, next_PC_select}, {30'd0, e[67:66]});
            check("target_PC", target_PC, e[65:34]);
            check("flush_fetch", {31'd0, flush_fetch}, {31'd0, e[33]});
            check("flush_decode", {31'd0, flush_decode}, {31'd0, e[32]});
            check("redirect_count", redirect_count, e[31:0]);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          r_rst, r_tv, r_bv, r_jv, r_st, r_rdy;
        logic [31:0] r_tt, r_bt, r_jt;

        // reset held, then release with memory ready and no requests
        repeat (3) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        repeat (4) idle(1'b1, 1'b0);

        // branch and jump together: branch wins
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b1);
        idle(1'b1, 1'b0);

        // memory busy three cycles, jump then branch parked, branch applied
        drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h300, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 32'h400, 1'b0, '0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // stalled jump ignored; stalled trap applied
        drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h500, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b1, 32'h80, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);

        // parked branch outranks a new jump arriving as memory frees up
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 32'h600, 1'b0, '0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h700, 1'b0, 1'b1);
        // parked jump replaced by a simultaneous equal-rank jump
        drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h800, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h900, 1'b0, 1'b1);

        // reset in WAIT_MEM drops a parked trap
        drive_cycle(1'b0, 1'b1, 32'h80, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        repeat (2) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        repeat (3) idle(1'b1, 1'b0);

        // counter saturation
        preload_val = 32'hFFFF_FFFD;
        do_preload  = 1'b1;
        repeat (5) drive_cycle(1'b0, 1'b0, '0, 1'b1, 32'hA00, 1'b0, '0, 1'b0, 1'b1);
        idle(1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            r_tv  = ($urandom_range(0, 19) == 0);
            r_bv  = ($urandom_range(0, 99) < 15);
            r_jv  = ($urandom_range(0, 99) < 25);
            r_st  = ($urandom_range(0, 99) < 25);
            r_tt  = $urandom() & 32'hFFFF_FFFC;
            r_bt  = $urandom() & 32'hFFFF_FFFC;
            r_jt  = $urandom() & 32'hFFFF_FFFC;
            drive_cycle(r_rst, r_tv, r_tt, r_bv, r_bt, r_jv, r_jt, r_st, r_rdy);
        end

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 Parameters: CORE 0, core index; RESET_PC 0, boot address; ADDRESS_BITS 32, PC width.
REQ-002 clock  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-004 trap_valid / trap_target  in  1 / ADDRESS_BITS  trap or exception redirect request.
REQ-005 branch_valid / branch_target  in  1 / ADDRESS_BITS  resolved taken-branch redirect from execute.
REQ-006 jump_valid / jump_target  in  1 / ADDRESS_BITS  direct-jump redirect from decode.
REQ-007 stall  in  1  hazard stall from decode.
REQ-008 i_mem_ready  in  1  instruction memory accepts a new read address this cycle.
REQ-009 next_PC_select  out  2  to PC register: 00 increment, 01 hold, 10 load target_PC; 11 is never driven.
REQ-010 target_PC  out  ADDRESS_BITS  redirect address, valid only while next_PC_select=10, otherwise 0.
REQ-011 flush_fetch / flush_decode  out  1 / 1  kill the instruction in fetch / in decode.
REQ-012 redirect_count  out  32  saturating count of applied redirects.

Function
REQ-013 FSM states: BOOT, RUN, WAIT_MEM; pending redirect register {pending_valid, pending_rank[1:0], pending_target}.
REQ-014 BOOT: select=01 for exactly one cycle after reset release; next state RUN.
REQ-015 Request rank: trap 3 > branch 2 > jump 1; jump_valid is ignored while stall=1.
REQ-016 RUN, i_mem_ready=1, request present: select=10, target_PC=highest-rank target, same cycle (zero latency).
REQ-017 RUN, i_mem_ready=1, pending_valid=1, no new request of higher rank: apply pending_target with select=10; clear pending_valid at the edge.
REQ-018 RUN, i_mem_ready=1, no request/pending: select=01 if stall, else 00.
REQ-019 i_mem_ready=0 in any non-BOOT state: select=01; state goes to WAIT_MEM; any request is captured in the pending register.
REQ-020 Capture rule: a new request overwrites the pending entry iff its rank >= pending_rank or pending_valid=0; a trap always wins.
REQ-021 WAIT_MEM to RUN on first cycle with i_mem_ready=1; that cycle follows REQ-016..018 (pending applied with zero added latency).
REQ-022 Redirect outranks stall; stall never delays an applied redirect.
REQ-023 flush_fetch=1 in every cycle a request is captured or a redirect applied; flush_decode=1 additionally when the source rank >= 2 (trap/branch).
REQ-024 redirect_count increments by 1 per cycle with select=10; holds at 0xFFFFFFFF.
REQ-025 Simultaneous request and pending of equal or higher rank in an i_mem_ready=1 cycle: new request applied, pending cleared.

Reset
REQ-026 reset low: state=BOOT, pending_valid=0, pending_rank=0, pending_target=0, redirect_count=0.
REQ-027 While reset low: next_PC_select=01, target_PC=0, flush_fetch=0, flush_decode=0.
REQ-028 Reset asserted mid-WAIT_MEM discards the pending redirect; no redirect is applied after release.

Structure
REQ-029 State encodings, rank constants and select codes (00/01/10) live in the shared core package, used also by the PC register.
REQ-030 One sub-module, redirect_arbiter: combinational rank selection of trap/branch/jump plus pending entry.
REQ-031 Outputs next_PC_select, target_PC, flush_* are combinational from state and inputs; no latches.

Verification
REQ-032 Reset release, RESET_PC=0x100, i_mem_ready=1, no requests -> select 01 one cycle, then 00 each cycle; count 0.
REQ-033 RUN, branch_valid=1 target 0x200 with jump_valid=1 target 0x300 -> select 10, target_PC 0x200, flush_fetch=1, flush_decode=1, count 1.
REQ-034 i_mem_ready=0 three cycles, jump 0x300 in cycle 1, branch 0x400 in cycle 2 -> select 01 throughout, flush_fetch=1 in cycles 1-2; cycle ready returns: select 10, target 0x400.
REQ-035 stall=1 with jump_valid=1 target 0x500 -> select 01, flush_fetch=0; stall=1 with trap 0x80 -> select 10, target 0x80.
REQ-036 reset low during WAIT_MEM with pending trap 0x80 -> after release BOOT then 00, no select 10 observed.
REQ-037 Counter preloaded near max via forced redirects -> holds at 0xFFFFFFFF.
